// File: rtl/btb_next_pc.sv
// btb_next_pc: fetch-stage PC register with direct-mapped BTB prediction and mispredict redirect
//   clk, rst_n                : clock, asynchronous active-low reset
//   stall_F                   : hold pc_F
//   predict                   : PHT counter for pc_F (bit 1 = taken)
//   branch_E, jump_E, take_E  : resolving branch/jump and its actual outcome
//   pc_E, target_E            : PC and actual target of the resolving instruction
//   pred_taken_E, pred_target_E : prediction carried down the pipe with it
//   pc_F, pred_taken_F, pred_target_F : fetch PC and its prediction
//   flush                     : mispredict this cycle, kill younger F/D work
//   br_count, mp_count        : saturating resolved / mispredicted counts
module btb_next_pc #(
    parameter int ENTRIES = 16,
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_F,
    input  logic [1:0]      predict,
    input  logic            branch_E,
    input  logic            jump_E,
    input  logic            take_E,
    input  logic [PC_W-1:0] pc_E,
    input  logic [PC_W-1:0] target_E,
    input  logic            pred_taken_E,
    input  logic [PC_W-1:0] pred_target_E,
    output logic [PC_W-1:0] pc_F,
    output logic            pred_taken_F,
    output logic [PC_W-1:0] pred_target_F,
    output logic            flush,
    output logic [15:0]     br_count,
    output logic [15:0]     mp_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] is_jump;
    logic [TAG_W-1:0]   tag [ENTRIES];
    logic [PC_W-1:0]    target [ENTRIES];
    logic [IDX_W-1:0]   idx_F;
    logic [IDX_W-1:0]   idx_E;
    logic               resolve;
    logic               actual_taken;
    logic               mispredict;
    logic [PC_W-1:0]    target_al;
    logic [PC_W-1:0]    actual_next;
    logic               unused;

    assign unused = ^{predict[0], pred_taken_E, pc_E[1:0], target_E[1:0]};

    assign idx_F = pc_F[IDX_W+1:2];
    assign idx_E = pc_E[IDX_W+1:2];
    assign pred_taken_F = valid[idx_F] && tag[idx_F] == pc_F[PC_W-1:IDX_W+2] && (is_jump[idx_F] || predict[1]);
    assign pred_target_F = pred_taken_F ? target[idx_F] : pc_F + PC_W'(4);

    assign resolve = branch_E | jump_E;
    assign actual_taken = jump_E | (branch_E & take_E);
    // Word-align everything that can become pc_F.
    assign target_al = {target_E[PC_W-1:2], 2'b00};
    assign actual_next = actual_taken ? target_al : {pc_E[PC_W-1:2], 2'b00} + PC_W'(4);
    // Gated by rst_n so flush stays low while reset is held.
    assign mispredict = rst_n && resolve && actual_next != pred_target_E;
    assign flush = mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_F     <= RESET_PC;
            valid    <= '0;
            br_count <= '0;
            mp_count <= '0;
        end else begin
            pc_F <= mispredict ? actual_next : stall_F ? pc_F : pred_target_F;
            if (actual_taken) valid[idx_E] <= 1'b1;
            if (resolve && br_count != 16'hFFFF) br_count <= br_count + 16'd1;
            if (mispredict && mp_count != 16'hFFFF) mp_count <= mp_count + 16'd1;
        end
    end

    // Payload only matters while valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (actual_taken) begin
            tag[idx_E]     <= pc_E[PC_W-1:IDX_W+2];
            target[idx_E]  <= target_al;
            is_jump[idx_E] <= jump_E;
        end
    end
endmodule

// File: tb/tb_btb_next_pc.sv
// tb_btb_next_pc: randomized + directed scoreboard bench for btb_next_pc
module tb_btb_next_pc;
    localparam int ENTRIES = 16;
    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_F = 1'b0;
    logic [1:0]  predict = 2'b00;
    logic        branch_E = 1'b0;
    logic        jump_E = 1'b0;
    logic        take_E = 1'b0;
    logic [31:0] pc_E = '0;
    logic [31:0] target_E = '0;
    logic        pred_taken_E = 1'b0;
    logic [31:0] pred_target_E = '0;
    logic [31:0] pc_F;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;
    logic        flush;
    logic [15:0] br_count;
    logic [15:0] mp_count;

    btb_next_pc #(.ENTRIES(ENTRIES), .PC_W(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .stall_F(stall_F), .predict(predict),
        .branch_E(branch_E), .jump_E(jump_E), .take_E(take_E), .pc_E(pc_E),
        .target_E(target_E), .pred_taken_E(pred_taken_E), .pred_target_E(pred_target_E),
        .pc_F(pc_F), .pred_taken_F(pred_taken_F), .pred_target_F(pred_target_F),
        .flush(flush), .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptg;
        logic        fl;
        logic [15:0] br;
        logic [15:0] mp;
    } exp_t;

    exp_t q[$];

    // Reference model: BTB slot remembers the full word address of its owner.
    logic [31:0] m_pc = RPC;
    bit          m_v[ENTRIES];
    logic [29:0] m_own[ENTRIES];
    logic [31:0] m_tgt[ENTRIES];
    bit          m_j[ENTRIES];
    int          m_br = 0;
    int          m_mp = 0;
    int          n_pass = 0;
    int          n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    endtask

    task automatic cyc(input bit rn, input bit st, input logic [1:0] pr, input bit br,
                       input bit jp, input bit tk, input logic [31:0] pe,
                       input logic [31:0] te, input logic [31:0] pte);
        exp_t e;
        int i;
        bit pt, res, tkn, mis;
        logic [31:0] ptg, an, tg;
        @(posedge clk);
        #1;
        rst_n = rn; stall_F = st; predict = pr; branch_E = br; jump_E = jp; take_E = tk;
        pc_E = pe; target_E = te; pred_target_E = pte; pred_taken_E = 1'($urandom);
        if (!rn) begin
            m_pc = RPC; m_br = 0; m_mp = 0;
            foreach (m_v[k]) m_v[k] = 0;
            e.pc = RPC; e.pt = 1'b0; e.ptg = RPC + 32'd4; e.fl = 1'b0; e.br = '0; e.mp = '0;
            q.push_back(e);
            return;
        end
        i = int'(m_pc[31:2] % 30'(ENTRIES));
        pt = m_v[i] && m_own[i] == m_pc[31:2] && (m_j[i] || pr[1]);
        ptg = pt ? m_tgt[i] : m_pc + 32'd4;
        res = br | jp;
        tkn = jp | (br & tk);
        tg = te & ~32'd3;
        an = tkn ? tg : (pe & ~32'd3) + 32'd4;
        mis = res && an != pte;
        e.pc = m_pc; e.pt = pt; e.ptg = ptg; e.fl = mis; e.br = 16'(m_br); e.mp = 16'(m_mp);
        q.push_back(e);
        m_pc = mis ? an : st ? m_pc : ptg;
        if (tkn) begin
            i = int'(pe[31:2] % 30'(ENTRIES));
            m_v[i] = 1; m_own[i] = pe[31:2]; m_tgt[i] = tg; m_j[i] = jp;
        end
        if (res && m_br < 65535) m_br++;
        if (mis && m_mp < 65535) m_mp++;
    endtask

    task automatic idle(input int n, input logic [1:0] pr);
        repeat (n) cyc(1, 0, pr, 0, 0, 0, '0, '0, '0);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc_F", pc_F, e.pc);
                chk("pred_taken_F", 32'(pred_taken_F), 32'(e.pt));
                chk("pred_target_F", pred_target_F, e.ptg);
                chk("flush", 32'(flush), 32'(e.fl));
                chk("br_count", 32'(br_count), 32'(e.br));
                chk("mp_count", 32'(mp_count), 32'(e.mp));
            end
        end
    end

    initial begin
        logic [31:0] pe, te, pte;
        int kind, r;
        cyc(0, 0, 2'b00, 0, 0, 0, '0, '0, '0);
        cyc(0, 0, 2'b00, 0, 1, 0, 32'h40, 32'h80, 32'h0);
        idle(3, 2'b00);
        // cold taken branch at 0x104 -> 0x200
        cyc(1, 0, 2'b00, 1, 0, 1, 32'h104, 32'h200, 32'h108);
        cyc(1, 0, 2'b00, 1, 0, 0, 32'h100, 32'h0, 32'h999);
        idle(1, 2'b11);
        cyc(1, 0, 2'b00, 1, 0, 0, 32'h100, 32'h0, 32'h999);
        cyc(1, 0, 2'b01, 1, 0, 0, 32'h104, 32'h0, 32'h108);
        idle(1, 2'b00);
        // jump at 0x40, refetch, then alias replacement
        cyc(1, 0, 2'b00, 0, 1, 0, 32'h40, 32'h80, 32'h44);
        cyc(1, 0, 2'b00, 1, 0, 0, 32'h3C, 32'h0, 32'h0);
        idle(1, 2'b00);
        cyc(1, 0, 2'b00, 1, 0, 1, 32'h40 + 32'(4 * ENTRIES), 32'h300, 32'h0);
        cyc(1, 0, 2'b00, 1, 1, 0, 32'h3C, 32'h0, 32'h0);
        cyc(1, 0, 2'b00, 1, 0, 0, 32'h3C, 32'h0, 32'h0);
        idle(1, 2'b11);
        // stall with mispredict, then plain stall
        cyc(1, 1, 2'b00, 0, 1, 0, 32'h10, 32'h500, 32'h0);
        repeat (3) cyc(1, 1, 2'b00, 0, 0, 0, '0, '0, '0);
        idle(1, 2'b00);
        // wrap and unaligned target
        cyc(1, 0, 2'b00, 0, 1, 0, 32'h20, 32'hFFFF_FFFC, 32'h0);
        idle(2, 2'b00);
        cyc(1, 0, 2'b00, 0, 1, 0, 32'h24, 32'h203, 32'h0);
        idle(1, 2'b00);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            kind = $urandom_range(0, 3);
            pe = 32'($urandom_range(0, 47)) << 2;
            te = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            pte = r == 0 ? pe + 32'd4 : r == 1 ? te & ~32'd3 : r == 2 ? m_pc : 32'($urandom_range(0, 63)) << 2;
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 4) == 0, 2'($urandom),
                kind[0], kind[1], 1'($urandom), pe, te, pte);
        end
        // saturate both counters
        repeat (65540) cyc(1, 0, 2'b00, 0, 1, 0, 32'h0, 32'h10, 32'h14);
        idle(2, 2'b00);
        cyc(0, 0, 2'b00, 0, 1, 0, 32'h0, 32'h10, 32'h14);
        idle(3, 2'b00);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/btb_next_pc.md
# btb_next_pc

Fetch-stage next-PC generator that owns the PC register, a direct-mapped branch target buffer (BTB) and misprediction recovery. Each cycle it presents `pc_F` to the pattern history table and to instruction memory. It combines the BTB hit with the PHT's 2-bit `predict` to choose the next fetch address. It redirects fetch when the execute stage resolves a branch or jump differently from the prediction.

## Interface
- `ENTRIES`, 16 — BTB entries; power of two, ≥2.
- `PC_W`, 32 — PC width; `IDX_W = log2(ENTRIES)`, tag width `PC_W-IDX_W-2`.
- `RESET_PC`, 0 — fetch address after reset.

- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `stall_F` in 1 — hold `pc_F` (hazard stall).
- `predict` in 2 — PHT counter for current `pc_F`; `predict[1]`=taken.
- `branch_E` in 1 — conditional branch resolving in E.
- `jump_E` in 1 — unconditional jump (JAL/JALR) resolving in E.
- `take_E` in 1 — actual branch outcome (ignored when `jump_E`).
- `pc_E` in PC_W — PC of resolving instruction.
- `target_E` in PC_W — actual target.
- `pred_taken_E` in 1 — `pred_taken_F` value carried down the pipe with this instruction.
- `pred_target_E` in PC_W — predicted next PC carried down the pipe.
- `pc_F` out PC_W — current fetch PC (registered).
- `pred_taken_F` out 1 — prediction for `pc_F`.
- `pred_target_F` out PC_W — predicted next PC for `pc_F`.
- `flush` out 1 — kill F/D instructions younger than E (combinational, one cycle per mispredict).
- `br_count` out 16 — resolved branches+jumps, saturating.
- `mp_count` out 16 — mispredicts, saturating.

## Operation
- BTB entry: `valid`, `tag`, `target[PC_W-1:0]`, `is_jump`.
- Lookup (combinational on `pc_F`): index `pc_F[IDX_W+1:2]`, tag `pc_F[PC_W-1:IDX_W+2]`.
  - `hit` = valid & tag equal.
  - `pred_taken_F` = `hit & (is_jump | predict[1])`.
  - `pred_target_F` = `pred_taken_F ? entry.target : pc_F+4`.
- Resolution: `actual_taken = jump_E | (branch_E & take_E)`. `actual_next = actual_taken ? target_E : pc_E+4`.
  - `mispredict = (branch_E|jump_E) & (actual_next != pred_target_E)`.
  - `flush = mispredict`.
- Next-PC priority, applied at the clock edge:
  1. `mispredict` → `actual_next`; overrides `stall_F`.
  2. `stall_F` → hold.
  3. Otherwise → `pred_target_F`.
- BTB update, for `branch_E|jump_E`:
  - Actual taken: write the entry at `pc_E`'s index with valid=1, tag from `pc_E`, `target_E`, and `is_jump=jump_E`. This replaces any conflicting entry.
  - Branch not taken: no write.
  - `branch_E` and `jump_E` both high: treat as jump.
- Same-cycle lookup and update at the same index: the lookup sees the old contents; the new entry is visible from the next cycle.
- Counters:
  - `br_count` +1 per `branch_E|jump_E`.
  - `mp_count` +1 per mispredict.
  - Both saturate at 0xFFFF.
- PC arithmetic is modulo 2^PC_W; `pc_F+4` wraps from 0xFFFFFFFC to 0.
- `pc_F[1:0]` is always 0: the low two bits of `target_E` are forced to 0 on load.

## Timing
- Reset (async assert, `rst_n`=0):
  - `pc_F`=`RESET_PC`.
  - All valid bits 0, so `pred_taken_F`=0 and `pred_target_F`=`RESET_PC+4`.
  - Counters 0; `flush`=0.
  - Reset asserted mid-operation discards any in-flight redirect.
- Release: the first edge with `rst_n`=1 loads `RESET_PC+4`, unless stalled or a mispredict is present.
- Lookup latency 0: the prediction is valid in the same cycle as `pc_F`.
- Redirect latency 1: `flush` is high in cycle N, and `pc_F`=`actual_next` in cycle N+1.
- BTB write takes effect at the edge ending the resolve cycle.
- No handshake: the E-side inputs are single-cycle pulses, valid in the cycle asserted.

## Test plan
- Reset with `RESET_PC`=0x100 and no E activity → `pc_F` sequence 0x100, 0x104, 0x108; `pred_taken_F`=0; counters 0.
- Cold taken branch: `branch_E`=1, `take_E`=1, `pc_E`=0x104, `target_E`=0x200, `pred_target_E`=0x108 → `flush`=1 that cycle, next `pc_F`=0x200, `br_count`=1, `mp_count`=1. On the next fetch of 0x104 with `predict`=2'b11 → `pred_taken_F`=1, `pred_target_F`=0x200.
- Same 0x104 entry with `predict`=2'b01 → `pred_target_F`=0x108. Then resolve not-taken with `pred_target_E`=0x108 → no flush, `mp_count` unchanged.
- Jump at 0x40 to 0x80, then refetch 0x40 with `predict`=2'b00 → `pred_taken_F`=1 (is_jump). Then alias 0x40+4·ENTRIES taken to 0x300 → the entry is replaced, and 0x40 no longer hits.
- `stall_F`=1 together with a mispredict to 0x500 → `pc_F`=0x500 next cycle. `stall_F`=1 alone → `pc_F` held for 3 cycles.
- Force `mp_count` and `br_count` to 0xFFFF via repeated mispredicts → both stay at 0xFFFF. Assert `rst_n` low mid-stream → immediate clear to 0, `pc_F`=`RESET_PC`.
